// File: rtl/fifo_burst_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_burst_reader_pkg
//  Description : Shared types and constants for the FIFO burst reader:
//                FSM state encoding, output buffer depth, sideband width.
//  Revision    : 1.0  initial release
// ============================================================================
package fifo_burst_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Output buffer depth and the width of its occupancy count
    localparam int BUF_DEPTH = 2;
    localparam int BUF_CNT_W = 2;

    // Sideband bits carried with each word: {eop, sop}
    localparam int SIDE_WIDTH = 2;

endpackage
`default_nettype wire

// File: rtl/fifo_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_skid_buf
//  Description : Two-entry registered valid/ready buffer. The head register
//                drives the output directly; occupancy is exported so the
//                producer can run a credit scheme and never overflow it.
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_skid_buf
    import fifo_burst_reader_pkg::*;
#(
    parameter int WIDTH = 18
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [BUF_CNT_W-1:0] count
);

    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic             pop;

    assign out_valid = (count != '0);
    assign out_data  = head;
    assign pop       = out_valid && out_ready;

    // Head/tail shift register; push and pop in the same cycle keep occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            case ({in_valid, pop})
                2'b10: begin
                    if (count == '0) head <= in_data;
                    else             tail <= in_data;
                    count <= count + BUF_CNT_W'(1);
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - BUF_CNT_W'(1);
                end
                2'b11: begin
                    if (count == BUF_CNT_W'(1)) begin
                        head <= in_data;
                    end else begin
                        head <= tail;
                        tail <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_burst_reader
//  Description : Pops fixed-length bursts from a FIFO (1-cycle read latency)
//                once a whole burst is stored and streams them out on a
//                valid/ready interface with sop/eop markers.
//                Optional: define FIFO_BURST_READER_TIMEOUT_EN to flush a
//                residue smaller than BURST_LEN after TIMEOUT_CYCLES of
//                waiting in IDLE.
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
`ifdef FIFO_BURST_READER_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES = 256,
`endif
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_BITS  = 10,
    parameter int BURST_LEN  = 8,
    parameter int CNT_BITS   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [ADDR_BITS-1:0]  fifo_usedw,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_req,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_sop,
    output logic                  m_eop,
    output logic [CNT_BITS-1:0]   burst_cnt,
    output logic                  busy
);

    localparam int                   BUF_W       = DATA_WIDTH + SIDE_WIDTH;
    localparam logic [ADDR_BITS-1:0] BURST_LEN_W = ADDR_BITS'(BURST_LEN);

    state_t                 state;
    logic [ADDR_BITS-1:0]   remaining;
    logic                   first_word;
    logic                   inflight;
    logic                   inflight_sop;
    logic                   inflight_eop;
    logic [BUF_CNT_W-1:0]   buf_count;
    logic [BUF_W-1:0]       buf_out;
    logic                   xfer;
    logic [BUF_CNT_W:0]     credit_used;
    logic                   start_full;
    logic                   start_timeout;
    logic                   start;
    logic [ADDR_BITS-1:0]   start_len;

    assign xfer = m_valid && m_ready;

    // Slots that will be occupied after this edge: stored words plus the read
    // returning now, minus the word leaving now
    assign credit_used = {1'b0, buf_count} + {{BUF_CNT_W{1'b0}}, inflight}
                       - {{BUF_CNT_W{1'b0}}, xfer};

    assign fifo_rd_req = (state == ST_BURST) && (remaining != '0)
                      && (credit_used < (BUF_CNT_W+1)'(BUF_DEPTH));

    assign busy = (state != ST_IDLE);

    assign start_full = en && (fifo_usedw >= BURST_LEN_W);
    assign start      = start_full || start_timeout;
    assign start_len  = start_full ? BURST_LEN_W : fifo_usedw;

`ifdef FIFO_BURST_READER_TIMEOUT_EN
    logic [31:0] idle_cycles;
    logic        residue_wait;

    assign residue_wait  = (state == ST_IDLE) && en && (fifo_usedw != '0)
                        && (fifo_usedw < BURST_LEN_W);
    assign start_timeout = residue_wait && (idle_cycles == 32'(TIMEOUT_CYCLES - 1));

    // Count consecutive cycles spent waiting on a residue; restart otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cycles <= '0;
        end else if (!residue_wait || start_timeout) begin
            idle_cycles <= '0;
        end else begin
            idle_cycles <= idle_cycles + 32'd1;
        end
    end
`else
    assign start_timeout = 1'b0;
`endif

    // Burst sequencer: issues reads, tags them, and closes the burst on eop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            remaining    <= '0;
            first_word   <= 1'b0;
            inflight     <= 1'b0;
            inflight_sop <= 1'b0;
            inflight_eop <= 1'b0;
            burst_cnt    <= '0;
        end else begin
            inflight <= fifo_rd_req;
            if (fifo_rd_req) begin
                inflight_sop <= first_word;
                inflight_eop <= (remaining == ADDR_BITS'(1));
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        remaining  <= start_len;
                        first_word <= 1'b1;
                        state      <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (fifo_rd_req) begin
                        remaining  <= remaining - ADDR_BITS'(1);
                        first_word <= 1'b0;
                        if (remaining == ADDR_BITS'(1)) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (xfer && m_eop) begin
                        burst_cnt <= burst_cnt + CNT_BITS'(1);
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    fifo_skid_buf #(
        .WIDTH (BUF_W)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inflight),
        .in_data   ({inflight_eop, inflight_sop, fifo_data}),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .out_data  (buf_out),
        .count     (buf_count)
    );

    assign {m_eop, m_sop, m_data} = buf_out;

`ifndef SYNTHESIS
    // A pop from an empty FIFO means the occupancy gating has been broken
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(fifo_rd_req && fifo_empty))
                else $fatal(1, "fifo_burst_reader: read request while FIFO empty");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_burst_reader
//  Description : Self-checking bench. Models the FIFO as a queue and predicts
//                the stream as the written words in order, grouped into
//                bursts of the current burst length.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_burst_reader;

    localparam int DW = 16;
    localparam int AB = 10;
    localparam int BL = 8;
    localparam int CB = 16;
`ifdef FIFO_BURST_READER_TIMEOUT_EN
    localparam int TB_TIMEOUT = 16;
    localparam int IDLE_WAIT  = 12;
`else
    localparam int IDLE_WAIT  = 1000;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [AB-1:0] fifo_usedw;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          fifo_rd_req;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_sop;
    logic          m_eop;
    logic [CB-1:0] burst_cnt;
    logic          busy;

    always #5 clk = ~clk;

    fifo_burst_reader #(
`ifdef FIFO_BURST_READER_TIMEOUT_EN
        .TIMEOUT_CYCLES (TB_TIMEOUT),
`endif
        .DATA_WIDTH (DW),
        .ADDR_BITS  (AB),
        .BURST_LEN  (BL),
        .CNT_BITS   (CB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .fifo_usedw  (fifo_usedw),
        .fifo_empty  (fifo_empty),
        .fifo_data   (fifo_data),
        .fifo_rd_req (fifo_rd_req),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_sop       (m_sop),
        .m_eop       (m_eop),
        .burst_cnt   (burst_cnt),
        .busy        (busy)
    );

    // Bench state: FIFO contents, expected stream, counters
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] next_wr = 16'h0001;
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            rx_total = 0;
    int            rd_seen = 0;
    int            pops = 0;
    int            last_rx_cyc = 0;
    int            wr_left = 0;
    int            rdy_mode = 1;
    int            cur_len = BL;
    int            beat = 0;
    bit            pop_pending = 0;
    bit            prev_stall = 0;
    logic [DW+1:0] prev_word = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_word();
        fifo_q.push_back(next_wr);
        exp_q.push_back(next_wr);
        next_wr = next_wr + 16'd1;
    endtask

    task automatic clear_model();
        fifo_q.delete();
        exp_q.delete();
        pop_pending = 0;
        prev_stall  = 0;
        beat        = 0;
        wr_left     = 0;
        fifo_data   = '0;
        fifo_usedw  = '0;
        fifo_empty  = 1'b1;
    endtask

    // One clock: update the FIFO model, drive m_ready, then sample what the
    // DUT presents for the coming rising edge
    task automatic cycle();
        @(negedge clk);
        if (pop_pending) begin
            if (fifo_q.size() == 0) chk("fifo_underflow", 1, 0);
            else fifo_data = fifo_q.pop_front();
            pops++;
        end
        if (wr_left > 0 && $urandom_range(0, 1) == 1) begin
            push_word();
            wr_left--;
        end
        fifo_usedw = AB'(fifo_q.size());
        fifo_empty = (fifo_q.size() == 0);
        case (rdy_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
        #1;
        if (prev_stall) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_word", {m_eop, m_sop, m_data}, prev_word);
        end
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                chk("extra_beat", 1, 0);
            end else begin
                chk("beat_data", m_data, exp_q.pop_front());
                chk("beat_sop", m_sop, beat == 0);
                chk("beat_eop", m_eop, beat == cur_len - 1);
                beat = (beat + 1) % cur_len;
            end
            rx_total++;
            last_rx_cyc = cyc;
        end
        prev_stall  = m_valid && !m_ready;
        prev_word   = {m_eop, m_sop, m_data};
        if (fifo_rd_req) rd_seen++;
        pop_pending = fifo_rd_req;
        cyc++;
    endtask

    task automatic run_until(input int target, input int budget);
        int n = 0;
        while (rx_total < target && n < budget) begin
            cycle();
            n++;
        end
        chk("rx_count", rx_total, target);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int t0;
        int n;
        int rd_base;
        int pop_base;

        rst_n   = 1'b0;
        en      = 1'b0;
        m_ready = 1'b0;
        clear_model();
        repeat (3) @(negedge clk);
        #1;
        // Reset state
        chk("rst_rd_req", fifo_rd_req, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_sop", m_sop, 0);
        chk("rst_eop", m_eop, 0);
        chk("rst_data", m_data, 0);
        chk("rst_cnt", burst_cnt, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;

        // Basic burst of 0x0001..0x0008 with m_ready high
        en = 1'b1;
        rdy_mode = 1;
        repeat (BL) push_word();
        base = rx_total;
        run_until(base + 1, 20);
        t0 = last_rx_cyc;
        run_until(base + BL, 20);
        chk("burst_span", last_rx_cyc - t0, BL - 1);
        repeat (3) cycle();
        chk("cnt_basic", burst_cnt, 1);
        chk("busy_after", busy, 0);

        // Threshold: one word short of a burst must not start reading
        repeat (BL - 1) push_word();
        rd_base = rd_seen;
        repeat (IDLE_WAIT) cycle();
        chk("thresh_no_req", rd_seen - rd_base, 0);
        push_word();
        n = 0;
        while (rd_seen == rd_base && n < 10) begin
            cycle();
            n++;
        end
        chk("thresh_latency_ok", n <= 2, 1);
        run_until(rx_total + BL, 40);
        repeat (3) cycle();
        chk("cnt_thresh", burst_cnt, 2);

        // Back-pressure: only two pops while stalled; en dropped mid-burst
        rdy_mode = 0;
        repeat (BL) push_word();
        base = rx_total;
        rd_base = rd_seen;
        pop_base = pops;
        repeat (30) begin
            cycle();
            if (rd_seen > rd_base) en = 1'b0;
        end
        chk("bp_pops", pops - pop_base, 2);
        chk("bp_no_rx", rx_total - base, 0);
        chk("bp_valid", m_valid, 1);
        rdy_mode = 1;
        run_until(base + BL, 50);
        repeat (3) cycle();
        chk("cnt_bp", burst_cnt, 3);
        chk("bp_fifo_empty", fifo_q.size(), 0);
        en = 1'b1;

        // Random ready and write timing over 100 bursts
        apply_reset();
        rdy_mode = 2;
        wr_left  = 100 * BL;
        base = rx_total;
        run_until(base + 100 * BL, 20000);
        rdy_mode = 1;
        repeat (4) cycle();
        chk("cnt_random", burst_cnt, 100);
        chk("exp_left", exp_q.size(), 0);
        chk("busy_random", busy, 0);

        // Reset after the third beat of a burst
        apply_reset();
        repeat (BL) push_word();
        run_until(rx_total + 3, 30);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rd_req", fifo_rd_req, 0);
        chk("mid_valid", m_valid, 0);
        chk("mid_sop", m_sop, 0);
        chk("mid_eop", m_eop, 0);
        chk("mid_data", m_data, 0);
        chk("mid_busy", busy, 0);
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("mid_cnt", burst_cnt, 0);
        repeat (BL) push_word();
        run_until(rx_total + BL, 40);
        repeat (3) cycle();
        chk("mid_recover_cnt", burst_cnt, 1);

`ifdef FIFO_BURST_READER_TIMEOUT_EN
        // Residue flushed as a short burst after the timeout
        apply_reset();
        cur_len = 3;
        rd_base = rd_seen;
        repeat (3) push_word();
        n = 0;
        while (rd_seen == rd_base && n < 60) begin
            cycle();
            n++;
        end
        chk("timeout_wait_ok", (n >= TB_TIMEOUT) && (n <= TB_TIMEOUT + 2), 1);
        run_until(rx_total + 3, 30);
        repeat (3) cycle();
        chk("cnt_timeout", burst_cnt, 1);
        cur_len = BL;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
